// File: rtl/hv_stream_packer.sv
// Buffers encoded hypervectors and serializes them into OW-bit AXI4-Stream beats.
// Optional HV_PACKER_DROP_CNT_EN adds a saturating drop_cnt output.
module hv_stream_packer #(
  parameter int DIM   = 1023,
  parameter int OW    = 64,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_start,
  input  logic [15:0]   job_len,
  input  logic          in_v,
  input  logic [DIM:0]  in_d,
  output logic [OW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
`ifdef HV_PACKER_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic          overflow
);

  localparam int BEATS = (DIM + 1) / OW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    rcv_q, rcv_d;
  logic           ovf_q, ovf_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [OW-1:0]  tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic           tlast_q, tlast_d;
  logic [DIM:0]   mem_q [DEPTH];

  logic           hs, pop, want, full;
  logic           push, drop, ld, start_ok;
  logic [AW-1:0]  rd_nx;
  logic [BW-1:0]  beat_nx;

  assign start_ok = (state_q == IDLE) & job_start & (job_len != 16'd0);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rcv_d    = rcv_q;
    ovf_d    = ovf_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    ld       = 1'b0;
    rd_nx    = rd_q + 1'b1;
    beat_nx  = beat_q + 1'b1;

    hs   = tvalid_q & m_tready;
    pop  = hs & (beat_q == LAST_B);
    want = (state_q == RUN) & in_v & (rcv_q < len_q);
    full = (cnt_q == FULL_C);
    push = want & (~full | pop);
    drop = want & full & ~pop;

    if (want) rcv_d = rcv_q + 16'd1;
    if (drop) ovf_d = 1'b1;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_nx;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // An empty buffer bypasses in_d so beat 0 appears the cycle after capture.
    if (hs & ~pop) begin
      beat_d  = beat_nx;
      tdata_d = mem_q[rd_q][beat_nx*OW +: OW];
      ld      = 1'b1;
    end else if (pop) begin
      beat_d = '0;
      if (cnt_q > ONE_C) begin
        tdata_d = mem_q[rd_nx][OW-1:0];
        ld      = 1'b1;
      end else if (push) begin
        tdata_d = in_d[OW-1:0];
        ld      = 1'b1;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end else if (~tvalid_q & push) begin
      beat_d  = '0;
      tdata_d = in_d[OW-1:0];
      ld      = 1'b1;
    end

    // Last beat is final only if nothing can still join the buffer behind it.
    if (ld) begin
      tvalid_d = 1'b1;
      tlast_d  = (beat_d == LAST_B) & (cnt_d == ONE_C) & (rcv_d == len_q);
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          len_d   = job_len;
          rcv_d   = 16'd0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if ((pop & tlast_q) | ((rcv_q == len_q) & (cnt_q == '0)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rcv_q    <= '0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rcv_q    <= rcv_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_d;
  end

`ifdef HV_PACKER_DROP_CNT_EN
  logic [15:0] dcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q <= '0;
    end else if (start_ok) begin
      dcnt_q <= '0;
    end else if (drop && dcnt_q != 16'hFFFF) begin
      dcnt_q <= dcnt_q + 16'd1;
    end
  end

  assign drop_cnt = dcnt_q;
`endif

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign busy     = (state_q == RUN);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_hv_stream_packer.sv
// Directed/randomized bench for hv_stream_packer against a beat-list model.
// Checks drop_cnt when HV_PACKER_DROP_CNT_EN is defined.
module tb_hv_stream_packer;

  localparam int DIM   = 1023;
  localparam int OW    = 64;
  localparam int DEPTH = 2;
  localparam int BEATS = (DIM + 1) / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [15:0]   job_len;
  logic          in_v;
  logic [DIM:0]  in_d;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          overflow;
`ifdef HV_PACKER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] obs_d [$];
  logic          obs_l [$];
  int            obs_c [$];
  logic [DIM:0]  exp_v [$];
  int            cyc = 0;
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  hv_stream_packer #(.DIM(DIM), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_start (job_start),
    .job_len   (job_len),
    .in_v      (in_v),
    .in_d      (in_d),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
`ifdef HV_PACKER_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall &&
          !(m_tvalid && m_tdata === prev_d && m_tlast === prev_l))
        stall_err <= stall_err + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_d     <= m_tdata;
      prev_l     <= m_tlast;
      if (m_tvalid && m_tready) begin
        obs_d.push_back(m_tdata);
        obs_l.push_back(m_tlast);
        obs_c.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    obs_c.delete();
    exp_v.delete();
  endtask

  task automatic start_job(input logic [15:0] len);
    job_start = 1'b1;
    job_len   = len;
    tick();
    job_start = 1'b0;
  endtask

  function automatic logic [DIM:0] rand_vec();
    logic [DIM:0] v;
    for (int i = 0; i < (DIM + 1) / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_tlast(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tlast) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_tlast_seen"}, 64'(found), 64'd1);
    if (found) begin
      @(negedge clk);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  // Expected stream: every accepted vector, low beat first, tlast on the very last beat.
  task automatic cmp_stream(input string tag);
    int n, mism, nl, lastpos;
    logic [DIM:0] v;
    n = exp_v.size() * BEATS;
    mism = 0;
    nl = 0;
    lastpos = -1;
    chk({tag, "_nbeats"}, 64'(obs_d.size()), 64'(n));
    for (int i = 0; i < obs_d.size(); i++) begin
      if (i < n) begin
        v = exp_v[i / BEATS];
        if (obs_d[i] !== v[(i % BEATS)*OW +: OW]) mism++;
      end
      if (obs_l[i]) begin
        nl++;
        lastpos = i;
      end
    end
    chk({tag, "_data_mism"}, 64'(mism), 64'd0);
    chk({tag, "_nlast"}, 64'(nl), 64'd1);
    chk({tag, "_lastpos"}, 64'(lastpos), 64'(n - 1));
  endtask

  initial begin
    logic [DIM:0] v, v0, v1;
    logic done;
    int se;

    rst = 1'b1;
    job_start = 1'b0;
    job_len = '0;
    in_v = 1'b0;
    in_d = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single vector, patterned beats, first-beat latency
    clear_obs();
    for (int k = 0; k < BEATS; k++) v[k*OW +: OW] = 64'hA5A5_0000_0000_0000 + 64'(k);
    exp_v.push_back(v);
    start_job(16'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    in_v = 1'b1;
    in_d = v;
    tick();
    in_v = 1'b0;
    @(negedge clk);
    chk("t1_lat_valid", 64'(m_tvalid), 64'd1);
    chk("t1_lat_data", 64'(m_tdata), 64'hA5A5_0000_0000_0000);
    wait_tlast("t1", 40);
    cmp_stream("t1");

    // three vectors 16 cycles apart: contiguous 48 beats
    tick();
    clear_obs();
    start_job(16'd3);
    for (int j = 0; j < 3; j++) begin
      v = rand_vec();
      exp_v.push_back(v);
      in_v = 1'b1;
      in_d = v;
      tick();
      in_v = 1'b0;
      if (j < 2) repeat (15) tick();
    end
    wait_tlast("t2", 100);
    cmp_stream("t2");
    if (obs_c.size() == 3 * BEATS)
      chk("t2_span", 64'(obs_c[3*BEATS-1] - obs_c[0]), 64'(3 * BEATS - 1));
    chk("t2_ovf", 64'(overflow), 64'd0);

    // burst of four on consecutive cycles: only DEPTH fit
    tick();
    clear_obs();
    start_job(16'd4);
    for (int j = 0; j < 4; j++) begin
      v = rand_vec();
      if (j < DEPTH) exp_v.push_back(v);
      in_v = 1'b1;
      in_d = v;
      tick();
    end
    in_v = 1'b0;
    wait_tlast("t3", 100);
    cmp_stream("t3");
    chk("t3_ovf", 64'(overflow), 64'd1);
`ifdef HV_PACKER_DROP_CNT_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

    // 30% ready duty: data held during stalls
    tick();
    clear_obs();
    se = stall_err;
    v0 = rand_vec();
    v1 = rand_vec();
    exp_v.push_back(v0);
    exp_v.push_back(v1);
    start_job(16'd2);
    done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      m_tready = ($urandom_range(0, 99) < 30);
      in_v = (c == 0 || c == 7);
      in_d = (c < 7) ? v0 : v1;
      tick();
      if (obs_l.size() > 0 && obs_l[obs_l.size()-1]) begin
        done = 1'b1;
        break;
      end
    end
    in_v = 1'b0;
    m_tready = 1'b1;
    chk("t4_done", 64'(done), 64'd1);
    tick();
    chk("t4_busy_after", 64'(busy), 64'd0);
    chk("t4_stall_err", 64'(stall_err - se), 64'd0);
    cmp_stream("t4");
    chk("t4_ovf", 64'(overflow), 64'd0);

    // reset in the middle of vector 0
    tick();
    clear_obs();
    start_job(16'd2);
    in_v = 1'b1;
    in_d = rand_vec();
    tick();
    in_v = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (obs_d.size() >= 6) begin
        done = 1'b1;
        break;
      end
    end
    chk("t5_six_beats", 64'(done), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_rst_tlast", 64'(m_tlast), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t5_beats_before_rst", 64'(obs_d.size()), 64'd6);
    clear_obs();
    v = rand_vec();
    exp_v.push_back(v);
    start_job(16'd1);
    in_v = 1'b1;
    in_d = v;
    tick();
    in_v = 1'b0;
    wait_tlast("t5b", 60);
    cmp_stream("t5b");
    chk("t5b_ovf", 64'(overflow), 64'd0);

    // zero-length job is ignored
    tick();
    clear_obs();
    start_job(16'd0);
    chk("t6_busy_now", 64'(busy), 64'd0);
    in_v = 1'b1;
    in_d = rand_vec();
    tick();
    in_v = 1'b0;
    repeat (20) tick();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_nbeats", 64'(obs_d.size()), 64'd0);
    chk("t6_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
